red_pitaya_na_sweep_master: RTL

// - Bus initiator for the IQ block's register port: runs a hardware network-analyzer sweep without CPU polling.
// - Per point: write frequency word to 0x108, which restarts the IQ averager. Poll until averaging ends, read the 62-bit I/Q sums, stream them out.
// - Sits between the housekeeping register file (config/start) and one IQ block's addr/wen/ren/ack/rdata/wdata port.

---
 rtl/na_sweep_pkg.sv | 46 ++++
 rtl/na_bus_xact.sv | 83 ++++++++
 rtl/red_pitaya_na_sweep_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/na_sweep_pkg.sv
// rtl/na_sweep_pkg.sv - shared constants, state type and helpers for the network-analyzer sweep master
package na_sweep_pkg;

    localparam logic [15:0] ADDR_FREQ    = 16'h0108;
    localparam logic [15:0] ADDR_ISUM_LO = 16'h0140;
    localparam logic [15:0] ADDR_ISUM_HI = 16'h0144;
    localparam logic [15:0] ADDR_QSUM_LO = 16'h0148;
    localparam logic [15:0] ADDR_QSUM_HI = 16'h014C;

    // Bit of the ISUM_LO word that reads 1 while the averager is still running
    localparam int STATUS_BIT = 31;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_F,
        S_GAP,
        S_POLL,
        S_RD_IL,
        S_RD_IH,
        S_RD_QL,
        S_RD_QH,
        S_EMIT,
        S_NEXT
    } state_t;

    // States that own exactly one bus transaction
    function automatic logic is_bus_state(input state_t s);
        case (s)
            S_WR_F, S_POLL, S_RD_IL, S_RD_IH, S_RD_QL, S_RD_QH: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    // Register address targeted by each bus state
    function automatic logic [15:0] state_addr(input state_t s);
        case (s)
            S_WR_F:          return ADDR_FREQ;
            S_POLL, S_RD_IL: return ADDR_ISUM_LO;
            S_RD_IH:         return ADDR_ISUM_HI;
            S_RD_QL:         return ADDR_QSUM_LO;
            S_RD_QH:         return ADDR_QSUM_HI;
            default:         return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/na_bus_xact.sv
// rtl/na_bus_xact.sv - single outstanding register-bus transaction engine (optional ack timeout: NA_SWEEP_ACK_TIMEOUT_EN)
module na_bus_xact #(
    parameter int ACKTIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        ack_i,
    input  logic [31:0] rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] rdata_o,
    output logic [15:0] addr_o,
    output logic [31:0] wdata_o,
    output logic        wen_o,
    output logic        ren_o
);

    logic        r_busy;
    logic        r_wen;
    logic        r_ren;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;

    assign busy_o  = r_busy;
    assign done_o  = r_busy & ack_i;
    assign rdata_o = rdata_i;
    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign wen_o   = r_wen;
    assign ren_o   = r_ren;

`ifdef NA_SWEEP_ACK_TIMEOUT_EN
    localparam int CW = $clog2(ACKTIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    // Count cycles spent waiting on the responder since the strobe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (!r_busy) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign timeout_o = r_busy & ~ack_i & (r_cnt == CW'(ACKTIMEOUT - 1));
`else
    // No timeout in this build: a transaction waits for ack_i indefinitely
    assign timeout_o = (ACKTIMEOUT < 0) && r_busy;
`endif

    // Launch on request: strobe for one cycle, hold address/data until ack or timeout
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy  <= 1'b0;
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= 1'b0;
            r_ren <= 1'b0;
            if (r_busy) begin
                if (ack_i || timeout_o) begin
                    r_busy <= 1'b0;
                end
            end else if (req_i) begin
                r_busy  <= 1'b1;
                r_wen   <= we_i;
                r_ren   <= ~we_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/red_pitaya_na_sweep_master.sv
// rtl/red_pitaya_na_sweep_master.sv - hardware network-analyzer sweep driving one IQ block register port (optional: NA_SWEEP_ACK_TIMEOUT_EN)
module red_pitaya_na_sweep_master
    import na_sweep_pkg::*;
#(
    parameter int PHASEBITS  = 32,
    parameter int IDXBITS    = 16,
    parameter int POLLGAP    = 8,
    parameter int ACKTIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [PHASEBITS-1:0] f_start_i,
    input  logic [PHASEBITS-1:0] f_step_i,
    input  logic [IDXBITS-1:0]   points_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [15:0]          addr_o,
    output logic                 wen_o,
    output logic                 ren_o,
    output logic [31:0]          wdata_o,
    input  logic                 ack_i,
    input  logic [31:0]          rdata_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [IDXBITS-1:0]   res_idx_o,
    output logic [61:0]          res_i_o,
    output logic [61:0]          res_q_o
);

    localparam int GAPW = (POLLGAP > 1) ? $clog2(POLLGAP) : 1;

    state_t               r_state;
    logic                 r_issued;
    logic                 r_abort;
    logic                 r_done;
    logic [PHASEBITS-1:0] r_freq;
    logic [PHASEBITS-1:0] r_fstep;
    logic [IDXBITS-1:0]   r_points;
    logic [IDXBITS-1:0]   r_idx;
    logic [GAPW-1:0]      r_gap;
    logic [61:0]          r_res_i;
    logic [61:0]          r_res_q;

    logic                 w_abort;
    logic                 w_req;
    logic                 w_we;
    logic [15:0]          w_addr;
    logic [31:0]          w_wdata;
    logic                 w_xbusy;
    logic                 w_xdone;
    logic                 w_tmo;
    logic [31:0]          w_xrdata;

    // A bus state issues its single request on the first cycle it is entered
    assign w_abort = abort_i | r_abort;
    assign w_req   = is_bus_state(r_state) & ~r_issued & ~w_abort;
    assign w_we    = (r_state == S_WR_F);
    assign w_addr  = state_addr(r_state);
    assign w_wdata = w_we ? 32'(r_freq) : 32'h0;

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign res_valid_o = (r_state == S_EMIT);
    assign res_idx_o   = r_idx;
    assign res_i_o     = r_res_i;
    assign res_q_o     = r_res_q;

`ifdef NA_SWEEP_ACK_TIMEOUT_EN
    logic r_err;
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    na_bus_xact #(
        .ACKTIMEOUT(ACKTIMEOUT)
    ) u_xact (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (w_req),
        .we_i     (w_we),
        .addr_i   (w_addr),
        .wdata_i  (w_wdata),
        .ack_i    (ack_i),
        .rdata_i  (rdata_i),
        .busy_o   (w_xbusy),
        .done_o   (w_xdone),
        .timeout_o(w_tmo),
        .rdata_o  (w_xrdata),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .wen_o    (wen_o),
        .ren_o    (ren_o)
    );

    // Sweep sequencer: write frequency, poll averager, read four sum words, emit, advance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_issued <= 1'b0;
            r_abort  <= 1'b0;
            r_done   <= 1'b0;
            r_freq   <= '0;
            r_fstep  <= '0;
            r_points <= '0;
            r_idx    <= '0;
            r_gap    <= '0;
            r_res_i  <= '0;
            r_res_q  <= '0;
`ifdef NA_SWEEP_ACK_TIMEOUT_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_req) begin
                r_issued <= 1'b1;
            end
            if (r_state == S_IDLE) begin
                r_issued <= 1'b0;
                r_abort  <= 1'b0;
                if (start_i) begin
`ifdef NA_SWEEP_ACK_TIMEOUT_EN
                    r_err    <= 1'b0;
`endif
                    r_freq   <= f_start_i;
                    r_fstep  <= f_step_i;
                    r_points <= points_i;
                    r_idx    <= '0;
                    if (points_i == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_state <= S_WR_F;
                    end
                end
            end else if (w_tmo) begin
`ifdef NA_SWEEP_ACK_TIMEOUT_EN
                r_err    <= 1'b1;
`endif
                r_state  <= S_IDLE;
                r_issued <= 1'b0;
                r_abort  <= 1'b0;
            end else if (w_abort) begin
                // Let an outstanding transaction finish on the bus, then drop everything
                if (!w_xbusy || w_xdone) begin
                    r_state  <= S_IDLE;
                    r_issued <= 1'b0;
                    r_abort  <= 1'b0;
                end else begin
                    r_abort <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_WR_F: begin
                        if (w_xdone) begin
                            r_issued <= 1'b0;
                            r_gap    <= '0;
                            r_state  <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (r_gap == GAPW'(POLLGAP - 1)) begin
                            r_state <= S_POLL;
                        end else begin
                            r_gap <= r_gap + GAPW'(1);
                        end
                    end
                    S_POLL: begin
                        if (w_xdone) begin
                            r_issued <= 1'b0;
                            if (w_xrdata[STATUS_BIT]) begin
                                r_gap   <= '0;
                                r_state <= S_GAP;
                            end else begin
                                r_state <= S_RD_IL;
                            end
                        end
                    end
                    S_RD_IL: begin
                        if (w_xdone) begin
                            r_issued       <= 1'b0;
                            r_res_i[30:0]  <= w_xrdata[30:0];
                            r_state        <= S_RD_IH;
                        end
                    end
                    S_RD_IH: begin
                        if (w_xdone) begin
                            r_issued       <= 1'b0;
                            r_res_i[61:31] <= w_xrdata[30:0];
                            r_state        <= S_RD_QL;
                        end
                    end
                    S_RD_QL: begin
                        if (w_xdone) begin
                            r_issued       <= 1'b0;
                            r_res_q[30:0]  <= w_xrdata[30:0];
                            r_state        <= S_RD_QH;
                        end
                    end
                    S_RD_QH: begin
                        if (w_xdone) begin
                            r_issued       <= 1'b0;
                            r_res_q[61:31] <= w_xrdata[30:0];
                            r_state        <= S_EMIT;
                        end
                    end
                    S_EMIT: begin
                        if (res_ready_i) begin
                            r_state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (r_idx == r_points - IDXBITS'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + IDXBITS'(1);
                            r_freq  <= r_freq + r_fstep;
                            r_state <= S_WR_F;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
